// File: rtl/fwd_source_pipe.sv
// fwd_source_pipe: X/M(/W) destination tracking and pending-write scoreboard.
// Optional W stage enabled by defining FWD_MW_EN.
module fwd_source_pipe #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int NUM_REGS = 2 ** REG_AW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  input  logic                issue_wr_en,
  input  logic [REG_AW-1:0]   issue_rd,
  input  logic                issue_mem_rd,
  input  logic                issue_set_in_decode,
  input  logic [DATA_W-1:0]   issue_dec_data,
  input  logic                stall_d,
  input  logic                flush,
  input  logic [DATA_W-1:0]   ex_result,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [REG_AW-1:0]   DX_regRd,
  output logic                DX_writeEn,
  output logic                DX_writeSetInDecode,
  output logic [DATA_W-1:0]   DX_regRdData,
  output logic [REG_AW-1:0]   XM_regRd,
  output logic                XM_writeEn,
  output logic                XM_memRead,
  output logic [DATA_W-1:0]   XM_regRdData,
  output logic [REG_AW-1:0]   MW_regRd,
  output logic                MW_writeEn,
  output logic [DATA_W-1:0]   MW_regRdData,
  output logic [NUM_REGS-1:0] pending,
  output logic                busy
);

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] rd;
    logic              mem;
    logic              sid;
    logic [DATA_W-1:0] data;
  } stage_t;

  stage_t x_q, x_nxt;
  stage_t m_q, m_nxt;

  logic              ins;
  logic              ret_v;
  logic [REG_AW-1:0] ret_rd;

  // flush and stall both turn the X entry into a bubble
  assign ins = issue_valid & issue_wr_en & ~flush & ~stall_d;

  always_comb begin
    x_nxt = '0;
    if (ins) begin
      x_nxt.we  = 1'b1;
      x_nxt.rd  = issue_rd;
      x_nxt.mem = issue_mem_rd;
      x_nxt.sid = issue_set_in_decode;
      x_nxt.data = issue_set_in_decode ?
                   issue_dec_data : '0;
    end
  end

  always_comb begin
    m_nxt = '0;
    if (x_q.we) begin
      m_nxt.we  = 1'b1;
      m_nxt.rd  = x_q.rd;
      m_nxt.mem = x_q.mem;
      m_nxt.data = x_q.sid ? x_q.data : ex_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      m_q <= '0;
    end else begin
      x_q <= x_nxt;
      m_q <= m_nxt;
    end
  end

  assign DX_regRd            = x_q.rd;
  assign DX_writeEn          = x_q.we;
  assign DX_writeSetInDecode = x_q.sid;
  assign DX_regRdData        = x_q.data;
  assign XM_regRd            = m_q.rd;
  assign XM_writeEn          = m_q.we;
  assign XM_memRead          = m_q.mem;
  assign XM_regRdData        = m_q.data;

`ifdef FWD_MW_EN
  stage_t w_q, w_nxt;

  always_comb begin
    w_nxt = '0;
    if (m_q.we) begin
      w_nxt.we  = 1'b1;
      w_nxt.rd  = m_q.rd;
      w_nxt.data = m_q.mem ? mem_rdata : m_q.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= '0;
    end else begin
      w_q <= w_nxt;
    end
  end

  assign MW_regRd     = w_q.rd;
  assign MW_writeEn   = w_q.we;
  assign MW_regRdData = w_q.data;
  assign ret_v        = w_q.we;
  assign ret_rd       = w_q.rd;
  assign busy         = x_q.we | m_q.we | w_q.we;

  logic unused_bits;
  assign unused_bits = ^{m_q.sid, w_q.mem, w_q.sid};
`else
  assign MW_regRd     = '0;
  assign MW_writeEn   = 1'b0;
  assign MW_regRdData = '0;
  assign ret_v        = m_q.we;
  assign ret_rd       = m_q.rd;
  assign busy         = x_q.we | m_q.we;

  logic unused_bits;
  assign unused_bits = ^{mem_rdata, m_q.sid};
`endif

  // one counter per register; the last stage leaving is the retire
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_sb
    logic [1:0] cnt;
    logic       inc;
    logic       dec;

    assign inc = ins & (issue_rd == REG_AW'(r));
    assign dec = ret_v & (ret_rd == REG_AW'(r));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= 2'd0;
      end else if (inc & ~dec) begin
        cnt <= cnt + 2'd1;
      end else if (dec & ~inc) begin
        cnt <= cnt - 2'd1;
      end
    end

    assign pending[r] = |cnt;
  end

endmodule

// File: tb/tb_fwd_source_pipe.sv
// Bench for fwd_source_pipe: vector table, corner sequences, random vs model.
// Honours FWD_MW_EN the same way the design does.
module tb_fwd_source_pipe;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NR = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          issue_valid, issue_wr_en;
  logic [AW-1:0] issue_rd;
  logic          issue_mem_rd, issue_set_in_decode;
  logic [DW-1:0] issue_dec_data;
  logic          stall_d, flush;
  logic [DW-1:0] ex_result, mem_rdata;
  logic [AW-1:0] DX_regRd, XM_regRd, MW_regRd;
  logic          DX_writeEn, DX_writeSetInDecode;
  logic          XM_writeEn, XM_memRead, MW_writeEn;
  logic [DW-1:0] DX_regRdData, XM_regRdData, MW_regRdData;
  logic [NR-1:0] pending;
  logic          busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fwd_source_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_wr_en(issue_wr_en),
    .issue_rd(issue_rd), .issue_mem_rd(issue_mem_rd),
    .issue_set_in_decode(issue_set_in_decode),
    .issue_dec_data(issue_dec_data),
    .stall_d(stall_d), .flush(flush),
    .ex_result(ex_result), .mem_rdata(mem_rdata),
    .DX_regRd(DX_regRd), .DX_writeEn(DX_writeEn),
    .DX_writeSetInDecode(DX_writeSetInDecode),
    .DX_regRdData(DX_regRdData),
    .XM_regRd(XM_regRd), .XM_writeEn(XM_writeEn),
    .XM_memRead(XM_memRead), .XM_regRdData(XM_regRdData),
    .MW_regRd(MW_regRd), .MW_writeEn(MW_writeEn),
    .MW_regRdData(MW_regRdData),
    .pending(pending), .busy(busy)
  );

  // reference model: a list of in-flight writes, one slot per stage
  typedef struct {
    bit       v;
    int       rd;
    bit       ld;
    bit       sid;
    int       data;
  } ent_t;

`ifdef FWD_MW_EN
  localparam int DEPTH = 3;
`else
  localparam int DEPTH = 2;
`endif

  ent_t pipe [3];

  task automatic model_clear();
    for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0, 0};
  endtask

  task automatic model_edge();
    ent_t nx;
    nx = '{0, 0, 0, 0, 0};
    if (issue_valid && issue_wr_en && !flush && !stall_d)
      nx = '{1, int'(issue_rd), issue_mem_rd, issue_set_in_decode,
             issue_set_in_decode ? int'(issue_dec_data) : 0};
    pipe[2] = '{0, 0, 0, 0, 0};
    if (pipe[1].v)
      pipe[2] = '{1, pipe[1].rd, 0, 0,
                  pipe[1].ld ? int'(mem_rdata) : pipe[1].data};
    pipe[1] = '{0, 0, 0, 0, 0};
    if (pipe[0].v)
      pipe[1] = '{1, pipe[0].rd, pipe[0].ld, 0,
                  pipe[0].sid ? pipe[0].data : int'(ex_result)};
    pipe[0] = nx;
  endtask

  function automatic logic [NR-1:0] model_pending();
    logic [NR-1:0] p;
    p = '0;
    for (int s = 0; s < DEPTH; s++)
      if (pipe[s].v) p[pipe[s].rd] = 1'b1;
    return p;
  endfunction

  function automatic bit model_busy();
    bit b;
    b = 0;
    for (int s = 0; s < DEPTH; s++) b = b | pipe[s].v;
    return b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("dx", {DX_writeEn, DX_regRd, DX_writeSetInDecode, DX_regRdData},
        {pipe[0].v, AW'(pipe[0].rd), pipe[0].sid, DW'(pipe[0].data)});
    chk("xm", {XM_writeEn, XM_regRd, XM_memRead, XM_regRdData},
        {pipe[1].v, AW'(pipe[1].rd), pipe[1].ld, DW'(pipe[1].data)});
`ifdef FWD_MW_EN
    chk("mw", {MW_writeEn, MW_regRd, MW_regRdData},
        {pipe[2].v, AW'(pipe[2].rd), DW'(pipe[2].data)});
`else
    chk("mw_tied", {MW_writeEn, MW_regRd, MW_regRdData}, 64'd0);
`endif
    chk("pending", pending, model_pending());
    chk("busy", busy, model_busy());
  endtask

  task automatic drive(input bit v, input bit we, input int rd,
                       input bit ld, input bit sid, input int dec,
                       input bit st, input bit fl, input int ex,
                       input int mr);
    issue_valid = v; issue_wr_en = we; issue_rd = AW'(rd);
    issue_mem_rd = ld; issue_set_in_decode = sid;
    issue_dec_data = DW'(dec); stall_d = st; flush = fl;
    ex_result = DW'(ex); mem_rdata = DW'(mr);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit v, we; int rd; bit ld, sid; int dec; bit st, fl; int ex, mr;
    bit dx_we; int dx_rd; bit dx_sid; int dx_d;
    bit xm_we; int xm_rd; bit xm_ld; int xm_d;
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl[0] = '{1,1,3,0,0,0,     0,0,16'h0000,0,      1,3,0,0,        0,0,0,0};
    tbl[1] = '{0,0,0,0,0,0,     0,0,16'h1234,0,      0,0,0,0,        1,3,0,16'h1234};
    tbl[2] = '{1,1,5,0,1,16'h00FF,0,0,16'h0000,0,    1,5,1,16'h00FF, 0,0,0,0};
    tbl[3] = '{0,0,0,0,0,0,     0,0,16'h5555,0,      0,0,0,0,        1,5,0,16'h00FF};
    tbl[4] = '{1,1,6,0,0,0,     1,0,16'h0000,0,      0,0,0,0,        0,0,0,0};
    tbl[5] = '{1,1,7,0,0,0,     1,1,16'h0000,0,      0,0,0,0,        0,0,0,0};
    tbl[6] = '{1,1,2,1,0,0,     0,0,16'h0000,0,      1,2,0,0,        0,0,0,0};
    tbl[7] = '{1,0,4,0,0,0,     0,0,16'h0AAA,0,      0,0,0,0,        1,2,1,16'h0AAA};
    tbl[8] = '{0,0,0,0,0,0,     0,0,16'h0000,16'hBEEF,0,0,0,0,       0,0,0,0};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    #1;
    chk("reset_out", {DX_writeEn, XM_writeEn, MW_writeEn, pending, busy,
                      DX_regRdData, XM_regRdData}, 64'd0);
    do_reset();

    for (int i = 0; i < 9; i++) begin
      vec_t t;
      t = tbl[i];
      drive(t.v, t.we, t.rd, t.ld, t.sid, t.dec, t.st, t.fl, t.ex, t.mr);
      step();
      chk($sformatf("tbl%0d", i),
          {XM_writeEn, XM_regRd, XM_memRead, XM_regRdData,
           DX_writeEn, DX_regRd, DX_writeSetInDecode, DX_regRdData},
          {t.xm_we, AW'(t.xm_rd), t.xm_ld, DW'(t.xm_d),
           t.dx_we, AW'(t.dx_rd), t.dx_sid, DW'(t.dx_d)});
      check_model();
    end
`ifdef FWD_MW_EN
    chk("load_mw", {MW_writeEn, MW_regRd, MW_regRdData},
        {1'b1, 3'd2, 16'hBEEF});
`endif

    // three back-to-back writes to r1, then drain
    begin
      bit exp_p [6];
`ifdef FWD_MW_EN
      exp_p = '{1, 1, 1, 1, 1, 0};
`else
      exp_p = '{1, 1, 1, 1, 0, 0};
`endif
      do_reset();
      for (int i = 0; i < 6; i++) begin
        if (i < 3) drive(1, 1, 1, 0, 0, 0, 0, 0, 16'h0010 + i, 0);
        else       drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk($sformatf("r1_pend%0d", i), pending[1], exp_p[i]);
        check_model();
      end
    end

    // reset asserted between edges clears everything at once
    drive(1, 1, 4, 0, 0, 0, 0, 0, 16'h7777, 0);
    step();
    step();
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("midreset", {DX_writeEn, XM_writeEn, MW_writeEn, DX_regRd,
                     XM_regRd, XM_regRdData, pending, busy}, 64'd0);
    check_model();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8,
            $urandom_range(0, NR - 1), $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 16'hFFFF),
            $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 16'hFFFF), $urandom_range(0, 16'hFFFF));
      step();
      check_model();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
